theta_ram_arbiter: RTL and testbench

- Shares the single-port wide theta RAM (64 lanes; 14-bit address and 19-bit data per lane; registered address; Q valid the cycle after the address is latched, gated by OE) between 2 requesters: the column-update engine and the correlation engine.
- Round-robin arbitration, at most one RAM command per cycle.
- Owns the RAM's A/WE/OE/D pins and registers read data back to the winning requester.
- Also runs an init sweep that zero-fills every RAM row before an OMP run.

---
 rtl/theta_ram_arbiter_pkg.sv | 37 +++
 rtl/theta_ram_arbiter_rr.sv | 46 ++++
 rtl/theta_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_theta_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/theta_ram_arbiter_pkg.sv
// Shared constants and types for the theta RAM arbiter: RAM geometry, packed
// bus widths and the controller state encoding.
`ifndef RAM_THETA_LANES
`define RAM_THETA_LANES 64
`endif
`ifndef RAM_THETA_LANE_AW
`define RAM_THETA_LANE_AW 14
`endif
`ifndef RAM_THETA_LANE_DW
`define RAM_THETA_LANE_DW 19
`endif
`ifndef RAM_THETA_DEPTH
`define RAM_THETA_DEPTH 16384
`endif

package theta_ram_arbiter_pkg;

  localparam int LANES     = `RAM_THETA_LANES;
  localparam int LANE_AW   = `RAM_THETA_LANE_AW;
  localparam int LANE_DW   = `RAM_THETA_LANE_DW;
  localparam int MEM_DEPTH = `RAM_THETA_DEPTH;

  localparam int ADDR_W = LANES * LANE_AW;
  localparam int DATA_W = LANES * LANE_DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    INIT = 2'd2
  } state_t;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/theta_ram_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when the grant is taken.
module rr_arbiter
  import theta_ram_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IW   = idx_w(N_REQ)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      if (!found && req[IW'(cand)]) begin
        found              = 1'b1;
        grant[IW'(cand)]   = 1'b1;
        grant_idx          = IW'(cand);
      end
    end
  end

  always_ff @(posedge CK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/theta_ram_arbiter.sv
// Shares the single-port wide theta RAM between two requesters with a
// round-robin grant, a registered command stage and a 3-cycle read return.
module theta_ram_arbiter #(
  parameter int LANES     = theta_ram_arbiter_pkg::LANES,
  parameter int LANE_AW   = theta_ram_arbiter_pkg::LANE_AW,
  parameter int LANE_DW   = theta_ram_arbiter_pkg::LANE_DW,
  parameter int MEM_DEPTH = theta_ram_arbiter_pkg::MEM_DEPTH,
  parameter int N_REQ     = 2
) (
  input  logic                             CK,
  input  logic                             RST,
  input  logic                             init_start,
  output logic                             init_busy,
  output logic                             init_done,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0]                 req_we,
  input  logic [N_REQ*LANES*LANE_AW-1:0]   req_addr,
  input  logic [N_REQ*LANES*LANE_DW-1:0]   req_wdata,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 rd_valid,
  output logic [LANES*LANE_DW-1:0]         rd_data,
  output logic [LANES*LANE_AW-1:0]         ram_A,
  output logic                             ram_WE,
  output logic                             ram_OE,
  output logic [LANES*LANE_DW-1:0]         ram_D,
  input  logic [LANES*LANE_DW-1:0]         ram_Q
);

  import theta_ram_arbiter_pkg::*;

  localparam int ADDR_W = LANES * LANE_AW;
  localparam int DATA_W = LANES * LANE_DW;
  localparam int ROW_W  = idx_w(MEM_DEPTH);
  localparam int IW     = idx_w(N_REQ);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MEM_DEPTH - 1);

  state_t            state, state_nx;
  logic [ROW_W-1:0]  init_row;
  logic              init_last;
  logic              arb_en;
  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     grant_idx;
  logic              rd1_valid;
  logic [IW-1:0]     rd1_src;
  logic [IW-1:0]     rd2_src;

  assign init_last = (state == INIT) && (init_row == LAST_ROW);

  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = ARB;
      ARB:     if (init_start) state_nx = INIT;
      INIT:    if (init_last) state_nx = ARB;
      default: state_nx = IDLE;
    endcase
  end

  // init_start takes priority over any request sampled in the same cycle.
  always_comb begin
    arb_en    = (state == ARB) && !init_start;
    init_busy = (state == INIT);
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .CK        (CK),
    .RST       (RST),
    .req       (req_valid & {N_REQ{arb_en}}),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Command stage feeds the RAM pins; ram_OE is the read stage that follows it,
  // and rd_data/rd_valid capture Q one cycle later.
  always_ff @(posedge CK) begin
    if (RST) begin
      ram_A     <= '0;
      ram_D     <= '0;
      ram_WE    <= 1'b0;
      ram_OE    <= 1'b0;
      rd1_valid <= 1'b0;
      rd1_src   <= '0;
      rd2_src   <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      init_row  <= '0;
      init_done <= 1'b0;
    end else begin
      ram_WE    <= 1'b0;
      ram_D     <= '0;
      rd1_valid <= 1'b0;
      init_done <= 1'b0;

      if (state == ARB && init_start) begin
        init_row <= '0;
        ram_A    <= '0;
        ram_WE   <= 1'b1;
      end else if (state == INIT) begin
        if (init_last) begin
          init_done <= 1'b1;
        end else begin
          init_row <= init_row + 1'b1;
          ram_A    <= {LANES{LANE_AW'(init_row + 1'b1)}};
          ram_WE   <= 1'b1;
        end
      end else if (accept) begin
        ram_A     <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        ram_WE    <= req_we[grant_idx];
        rd1_valid <= !req_we[grant_idx];
        rd1_src   <= grant_idx;
        if (req_we[grant_idx]) ram_D <= req_wdata[grant_idx*DATA_W +: DATA_W];
      end

      ram_OE   <= rd1_valid;
      rd2_src  <= rd1_src;
      rd_valid <= '0;
      if (ram_OE) begin
        rd_valid[rd2_src] <= 1'b1;
        rd_data           <= ram_Q;
      end
    end
  end

endmodule

// File: tb/tb_theta_ram_arbiter.sv
// Directed bench for theta_ram_arbiter with a behavioral registered-address
// RAM (MEM_DEPTH=8, contents preloaded to all ones).
module tb_theta_ram_arbiter;
  import theta_ram_arbiter_pkg::*;

  localparam int TB_DEPTH = 8;

  logic                  CK, RST;
  logic                  init_start, init_busy, init_done;
  logic [1:0]            req_valid, req_we, req_ready, rd_valid;
  logic [2*ADDR_W-1:0]   req_addr;
  logic [2*DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]     rd_data, ram_D, ram_Q;
  logic [ADDR_W-1:0]     ram_A;
  logic                  ram_WE, ram_OE;

  theta_ram_arbiter #(.MEM_DEPTH(TB_DEPTH), .N_REQ(2)) dut (
    .CK(CK), .RST(RST), .init_start(init_start), .init_busy(init_busy),
    .init_done(init_done), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .ram_A(ram_A), .ram_WE(ram_WE),
    .ram_OE(ram_OE), .ram_D(ram_D), .ram_Q(ram_Q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Behavioral RAM: address latched at the edge, Q driven from the latched row.
  logic [LANE_DW-1:0] mem [LANES][1 << LANE_AW];
  logic [ADDR_W-1:0]  a_lat;
  logic               preload;

  always @(posedge CK) begin
    if (preload) begin
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < (1 << LANE_AW); r++) mem[l][r] <= '1;
    end else if (ram_WE) begin
      for (int l = 0; l < LANES; l++)
        mem[l][ram_A[l*LANE_AW +: LANE_AW]] <= ram_D[l*LANE_DW +: LANE_DW];
    end
    a_lat <= ram_A;
  end

  always_comb begin
    ram_Q = '0;
    for (int l = 0; l < LANES; l++)
      if (ram_OE) ram_Q[l*LANE_DW +: LANE_DW] = mem[l][a_lat[l*LANE_AW +: LANE_AW]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp, input int lw);
    logic [DATA_W-1:0] m, a, e;
    int bad;
    m = ~({DATA_W{1'b1}} << lw);
    bad = -1;
    checks++;
    for (int l = LANES - 1; l >= 0; l--) begin
      a = (act >> (l * lw)) & m;
      e = (exp >> (l * lw)) & m;
      if (a !== e) bad = l;
    end
    if (bad >= 0) begin
      errors++;
      a = (act >> (bad * lw)) & m;
      e = (exp >> (bad * lw)) & m;
      $display("FAIL %s: lane %0d got %0h expected %0h", name, bad, a[31:0], e[31:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_vec(input int base);
    logic [DATA_W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LANE_DW +: LANE_DW] = LANE_DW'(base + l);
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] row_vec(input int row);
    logic [ADDR_W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LANE_AW +: LANE_AW] = LANE_AW'(row);
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] lane_vec();
    logic [ADDR_W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*LANE_AW +: LANE_AW] = LANE_AW'(l);
    return v;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input int a0, input int a1,
                       input int b0, input int b1);
    req_valid = v;
    req_we    = w;
    req_addr  = {row_vec(a1), row_vec(a0)};
    req_wdata = {data_vec(b1), data_vec(b0)};
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [1:0] we;
    int         a0, a1, b0, b1;
    logic [1:0] rdy;
    logic       wep;
    logic       oe;
    logic [1:0] rdv;
    int         rbase;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // valid we a0 a1 b0 b1 | ready WE OE rd_valid rd_base
    tbl = '{
      '{2'b01, 2'b01, 3, 0, 0,    0,    2'b01, 1'b0, 1'b0, 2'b00, 0},
      '{2'b01, 2'b00, 3, 0, 0,    0,    2'b01, 1'b1, 1'b0, 2'b00, 0},
      '{2'b10, 2'b10, 0, 3, 0,    500,  2'b10, 1'b0, 1'b0, 2'b00, 0},
      '{2'b01, 2'b01, 1, 0, 1000, 0,    2'b01, 1'b1, 1'b1, 2'b00, 0},
      '{2'b10, 2'b10, 0, 2, 0,    2000, 2'b10, 1'b1, 1'b0, 2'b01, 0},
      '{2'b11, 2'b00, 1, 2, 0,    0,    2'b01, 1'b1, 1'b0, 2'b00, 0},
      '{2'b11, 2'b00, 1, 2, 0,    0,    2'b10, 1'b0, 1'b0, 2'b00, 0},
      '{2'b11, 2'b00, 1, 2, 0,    0,    2'b01, 1'b0, 1'b1, 2'b00, 0},
      '{2'b11, 2'b00, 1, 2, 0,    0,    2'b10, 1'b0, 1'b1, 2'b01, 1000},
      '{2'b11, 2'b00, 1, 2, 0,    0,    2'b01, 1'b0, 1'b1, 2'b10, 2000},
      '{2'b11, 2'b00, 1, 2, 0,    0,    2'b10, 1'b0, 1'b1, 2'b01, 1000},
      '{2'b00, 2'b00, 0, 0, 0,    0,    2'b00, 1'b0, 1'b1, 2'b10, 2000},
      '{2'b00, 2'b00, 0, 0, 0,    0,    2'b00, 1'b0, 1'b1, 2'b01, 1000},
      '{2'b00, 2'b00, 0, 0, 0,    0,    2'b00, 1'b0, 1'b0, 2'b10, 2000},
      '{2'b10, 2'b00, 0, 3, 0,    0,    2'b10, 1'b0, 1'b0, 2'b00, 0},
      '{2'b00, 2'b00, 0, 0, 0,    0,    2'b00, 1'b0, 1'b0, 2'b00, 0},
      '{2'b00, 2'b00, 0, 0, 0,    0,    2'b00, 1'b0, 1'b1, 2'b00, 0},
      '{2'b00, 2'b00, 0, 0, 0,    0,    2'b00, 1'b0, 1'b0, 2'b10, 500}
    };

    // Reset and RAM preload.
    preload    = 1'b1;
    RST        = 1'b1;
    init_start = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    preload = 1'b0;
    tick();
    RST = 1'b0;
    drive(2'b11, 2'b00, 0, 0, 0, 0);
    #1;
    check("reset ready", 32'(req_ready), 0);
    check("reset ram_WE", 32'(ram_WE), 0);
    check("reset ram_OE", 32'(ram_OE), 0);
    check("reset rd_valid", 32'(rd_valid), 0);
    check("reset init_busy", 32'(init_busy), 0);
    check("reset init_done", 32'(init_done), 0);
    check_lanes("reset ram_A", DATA_W'(ram_A), '0, LANE_AW);
    check_lanes("reset ram_D", ram_D, '0, LANE_DW);
    check_lanes("reset rd_data", rd_data, '0, LANE_DW);
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    tick();

    // Init sweep colliding with a req1 read of row 5.
    init_start = 1'b1;
    drive(2'b10, 2'b00, 0, 5, 0, 0);
    #1;
    check("collide ready", 32'(req_ready), 0);
    tick();
    init_start = 1'b0;
    for (int k = 0; k < TB_DEPTH; k++) begin
      #1;
      check($sformatf("init%0d busy", k), 32'(init_busy), 1);
      check($sformatf("init%0d WE", k), 32'(ram_WE), 1);
      check($sformatf("init%0d OE", k), 32'(ram_OE), 0);
      check($sformatf("init%0d ready", k), 32'(req_ready), 0);
      check($sformatf("init%0d done", k), 32'(init_done), 0);
      check_lanes($sformatf("init%0d ram_A", k), DATA_W'(ram_A), DATA_W'(row_vec(k)), LANE_AW);
      check_lanes($sformatf("init%0d ram_D", k), ram_D, '0, LANE_DW);
      tick();
    end
    #1;
    check("init_done pulse", 32'(init_done), 1);
    check("init_done busy", 32'(init_busy), 0);
    check("init_done WE", 32'(ram_WE), 0);
    check("post-init ready", 32'(req_ready), 32'b10);
    tick();
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    #1;
    check("init_done once", 32'(init_done), 0);
    check("row5 cmd WE", 32'(ram_WE), 0);
    check_lanes("row5 cmd A", DATA_W'(ram_A), DATA_W'(row_vec(5)), LANE_AW);
    tick();
    #1;
    check("row5 OE", 32'(ram_OE), 1);
    tick();
    #1;
    check("row5 rd_valid", 32'(rd_valid), 32'b10);
    check_lanes("row5 rd_data", rd_data, '0, LANE_DW);
    tick();

    // Write/read ordering and round-robin vectors.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1);
      #1;
      check($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      check($sformatf("v%0d WE", i), 32'(ram_WE), 32'(tbl[i].wep));
      check($sformatf("v%0d OE", i), 32'(ram_OE), 32'(tbl[i].oe));
      check($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rdv));
      if (tbl[i].rdv != 2'b00)
        check_lanes($sformatf("v%0d rd_data", i), rd_data, data_vec(tbl[i].rbase), LANE_DW);
      tick();
    end

    // Reset one cycle after a read is accepted aborts it and clears the pointer.
    drive(2'b01, 2'b00, 1, 0, 0, 0);
    #1;
    check("abort accept", 32'(req_ready), 32'b01);
    tick();
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(2'b11, 2'b00, 1, 2, 0, 0);
    #1;
    check("abort idle ready", 32'(req_ready), 0);
    check("abort OE", 32'(ram_OE), 0);
    check("abort WE", 32'(ram_WE), 0);
    check("abort rd_valid a", 32'(rd_valid), 0);
    tick();
    #1;
    check("abort tie ready", 32'(req_ready), 32'b01);
    check("abort rd_valid b", 32'(rd_valid), 0);
    check("abort OE b", 32'(ram_OE), 0);
    tick();
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    #1;
    check("abort rd_valid c", 32'(rd_valid), 0);
    tick();
    #1;
    check("tie OE", 32'(ram_OE), 1);
    tick();
    #1;
    check("tie rd_valid", 32'(rd_valid), 32'b01);
    check_lanes("tie rd_data", rd_data, data_vec(1000), LANE_DW);
    tick();

    // Per-lane addressing: lane i at address i holds 100+i.
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {row_vec(0), lane_vec()};
    req_wdata = {data_vec(0), data_vec(100)};
    #1;
    check("lane wr ready", 32'(req_ready), 32'b01);
    check("lane wr OE", 32'(ram_OE), 0);
    tick();
    req_we = 2'b00;
    #1;
    check("lane rd ready", 32'(req_ready), 32'b01);
    check("lane wr WE", 32'(ram_WE), 1);
    check("lane wr OE2", 32'(ram_OE), 0);
    check_lanes("lane wr A", DATA_W'(ram_A), DATA_W'(lane_vec()), LANE_AW);
    check_lanes("lane wr D", ram_D, data_vec(100), LANE_DW);
    tick();
    req_valid = 2'b00;
    #1;
    check("lane rd WE", 32'(ram_WE), 0);
    check("lane rd OE0", 32'(ram_OE), 0);
    check_lanes("lane rd A", DATA_W'(ram_A), DATA_W'(lane_vec()), LANE_AW);
    tick();
    #1;
    check("lane rd OE1", 32'(ram_OE), 1);
    tick();
    #1;
    check("lane rd OE2", 32'(ram_OE), 0);
    check("lane rd_valid", 32'(rd_valid), 32'b01);
    check_lanes("lane rd_data", rd_data, data_vec(100), LANE_DW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
